// File: rtl/rom_sequencer_if.sv
// Bundles the playback control, ROM read port and output stream of rom_sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to the host/ROM side.
interface rom_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 10
);
    logic             start;
    logic             stop;
    logic             loop;
    logic [AW-1:0]    start_addr;
    logic [AW-1:0]    last_addr;
    logic             rom_ren;
    logic [AW-1:0]    rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport slave (
        input  start, stop, loop, start_addr, last_addr, rom_data,
        output rom_ren, rom_addr, data_out, data_valid, busy, done
    );

    modport master (
        output start, stop, loop, start_addr, last_addr, rom_data,
        input  rom_ren, rom_addr, data_out, data_valid, busy, done
    );
endinterface

// File: rtl/rom_sequencer.sv
// Rate-divided read controller for a synchronous-read ROM.
// It walks an address window and registers returned words into a valid-qualified stream.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_RUN    | issuing reads every DIV cycles over the window
// S_DRAIN1 | no new reads; last in-flight word returns from ROM
// S_DRAIN2 | done pulse, coincides with final data_valid
module rom_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int DIV   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    rom_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN1, S_DRAIN2} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d, addr_inc;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             loop_q;
    logic [AW-1:0]    start_q, last_q;
    logic             load;
    logic             ren;
    logic             rd_pend_q;
    logic             data_valid_q;
    logic [WIDTH-1:0] data_out_q;

    // DEPTH need not be a power of two, so wrap explicitly
    assign addr_inc = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        ren     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    addr_d  = bus.start_addr;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_DRAIN1;
                end else begin
                    ren   = (cnt_q == '0);
                    cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
                    if (ren) begin
                        if (addr_q != last_q)
                            addr_d = addr_inc;
                        else if (loop_q)
                            addr_d = start_q;
                        else
                            state_d = S_DRAIN1;
                    end
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            loop_q       <= 1'b0;
            start_q      <= '0;
            last_q       <= '0;
            rd_pend_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            if (load) begin
                loop_q  <= bus.loop;
                start_q <= bus.start_addr;
                last_q  <= bus.last_addr;
            end
            // rom_data is valid the cycle after ren, so it is captured one cycle later
            rd_pend_q    <= ren;
            data_valid_q <= rd_pend_q;
            if (rd_pend_q)
                data_out_q <= bus.rom_data;
        end
    end

    assign bus.rom_ren    = ren;
    assign bus.rom_addr   = addr_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DRAIN2);
endmodule
